// File: rtl/jk_excite_driver.sv
// JK flip-flop excitation driver.
// Holds the flip-flop in reset after power-up, then per accepted request drives
// the JK excitation toward the target. It returns j/k to hold, lets q settle,
// and checks the result against the target.
//
// state  | meaning
// -------+---------------------------------------------------------------
// INIT   | ff_reset_n low, counting down the flip-flop reset pulse
// IDLE   | req_ready high, waiting for a request
// DRIVE  | j/k carry the excitation derived from target and captured q
// SETTLE | j=k=0, waiting for q to settle
// CHECK  | q compared with target on the closing edge
module jk_excite_driver #(
    parameter int RST_CYCLES    = 2,
    parameter int DRIVE_CYCLES  = 1,
    parameter int SETTLE_CYCLES = 1,
    parameter bit USE_TOGGLE    = 1'b0,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_target,
    output logic             j,
    output logic             k,
    output logic             ff_reset_n,
    input  logic             q,
    input  logic             q_,
    output logic             done,
    output logic             mismatch,
    output logic             rail_err,
    output logic [ERR_W-1:0] err_count
);

    // One shared down-counter serves every timed state, so size it for the longest.
    localparam int MAX_A = (RST_CYCLES > DRIVE_CYCLES) ? RST_CYCLES : DRIVE_CYCLES;
    localparam int MAX_C = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          target_r;
    logic          exc_j;
    logic          exc_k;

    // Excitation from the live q at the accepting edge; holds always use 0/0.
    always_comb begin
        exc_j = 1'b0;
        exc_k = 1'b0;
        if (req_target != q) begin
            if (USE_TOGGLE) begin
                exc_j = 1'b1;
                exc_k = 1'b1;
            end else begin
                exc_j = req_target;
                exc_k = ~req_target;
            end
        end
    end

    // Sequencer with all outputs registered so j/k/ff_reset_n are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_INIT;
            cnt        <= CW'(RST_CYCLES - 1);
            target_r   <= 1'b0;
            ff_reset_n <= 1'b0;
            j          <= 1'b0;
            k          <= 1'b0;
            req_ready  <= 1'b0;
            done       <= 1'b0;
            mismatch   <= 1'b0;
            rail_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            done     <= 1'b0;
            mismatch <= 1'b0;
            case (state)
                S_INIT: begin
                    if (cnt == '0) begin
                        state      <= S_IDLE;
                        ff_reset_n <= 1'b1;
                        req_ready  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= S_DRIVE;
                        target_r  <= req_target;
                        j         <= exc_j;
                        k         <= exc_k;
                        cnt       <= CW'(DRIVE_CYCLES - 1);
                        req_ready <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (cnt == '0) begin
                        state <= S_SETTLE;
                        j     <= 1'b0;
                        k     <= 1'b0;
                        cnt   <= CW'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    done      <= 1'b1;
                    mismatch  <= (q != target_r);
                    if (q == q_) begin
                        rail_err <= 1'b1;
                    end
                    if ((q != target_r) && (err_count != {ERR_W{1'b1}})) begin
                        err_count <= err_count + 1'b1;
                    end
                end
                default: begin
                    state      <= S_INIT;
                    cnt        <= CW'(RST_CYCLES - 1);
                    ff_reset_n <= 1'b0;
                    j          <= 1'b0;
                    k          <= 1'b0;
                    req_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench for jk_excite_driver: set/reset encoding on one instance,
// toggle encoding on a second, each wired to a behavioural JK flip-flop.
module tb_jk_excite_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stuck = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       valid0 = 1'b0, target0 = 1'b0;
    logic       ready0, j0, k0, ffrn0, done0, mis0, rail0;
    logic [7:0] errc0;
    logic       fq0, q_in0, qb_in0;

    logic       valid1 = 1'b0, target1 = 1'b0;
    logic       ready1, j1, k1, ffrn1, done1, mis1, rail1;
    logic [7:0] errc1;
    logic       fq1;

    always #5 clk = ~clk;

    // Behavioural JK flip-flops; instance 0 can be forced to a broken 0/0 rail.
    always @(posedge clk) begin
        if (!ffrn0) fq0 <= 1'b0;
        else case ({j0, k0})
            2'b01:   fq0 <= 1'b0;
            2'b10:   fq0 <= 1'b1;
            2'b11:   fq0 <= ~fq0;
            default: fq0 <= fq0;
        endcase
        if (!ffrn1) fq1 <= 1'b0;
        else case ({j1, k1})
            2'b01:   fq1 <= 1'b0;
            2'b10:   fq1 <= 1'b1;
            2'b11:   fq1 <= ~fq1;
            default: fq1 <= fq1;
        endcase
    end

    assign q_in0  = stuck ? 1'b0 : fq0;
    assign qb_in0 = stuck ? 1'b0 : ~fq0;

    jk_excite_driver #(.USE_TOGGLE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(valid0), .req_ready(ready0),
        .req_target(target0), .j(j0), .k(k0), .ff_reset_n(ffrn0),
        .q(q_in0), .q_(qb_in0), .done(done0), .mismatch(mis0),
        .rail_err(rail0), .err_count(errc0)
    );

    jk_excite_driver #(.USE_TOGGLE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
        .req_target(target1), .j(j1), .k(k1), .ff_reset_n(ffrn1),
        .q(fq1), .q_(~fq1), .done(done1), .mismatch(mis1),
        .rail_err(rail1), .err_count(errc1)
    );

    // Starts at a negedge in an IDLE cycle of dut0, ends at the negedge of the done cycle.
    task automatic run_req0(input logic tgt, input logic ej, input logic ek,
                            input logic emis, input string tag);
        valid0  = 1'b1;
        target0 = tgt;
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        checks++;
        if (j0 !== ej || k0 !== ek || ready0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_drive: j=%b k=%b ready=%b, expected j=%b k=%b ready=0",
                     tag, j0, k0, ready0, ej, ek);
        end
        @(negedge clk);
        checks++;
        if (j0 !== 1'b0 || k0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_settle: j=%b k=%b done=%b, expected 0 0 0", tag, j0, k0, done0);
        end
        @(negedge clk);
        checks++;
        if (j0 !== 1'b0 || k0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_check: j=%b k=%b done=%b, expected 0 0 0", tag, j0, k0, done0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || mis0 !== emis || ready0 !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%b mismatch=%b ready=%b, expected 1 %b 1",
                     tag, done0, mis0, ready0, emis);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (ffrn0 !== (c == 3) || ready0 !== (c == 3) || j0 !== 1'b0 || k0 !== 1'b0 ||
                done0 !== 1'b0 || mis0 !== 1'b0 || rail0 !== 1'b0 || errc0 !== 8'd0) begin
                errors++;
                $display("FAIL reset_cycle%0d: ffrn=%b ready=%b j=%b k=%b done=%b mis=%b rail=%b err=%0d, expected ffrn=%b ready=%b rest 0",
                         c, ffrn0, ready0, j0, k0, done0, mis0, rail0, errc0, c == 3, c == 3);
            end
            if (c < 3) @(negedge clk);
        end
        checks++;
        if (fq0 !== 1'b0 || ready1 !== 1'b1 || ffrn1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ff: q=%b ready1=%b ffrn1=%b, expected q=0 ready1=1 ffrn1=1",
                     fq0, ready1, ffrn1);
        end
    endtask

    task automatic test_single();
        run_req0(1'b1, 1'b1, 1'b0, 1'b0, "single");
        checks++;
        if (fq0 !== 1'b1) begin
            errors++;
            $display("FAIL single_q: q=%b, expected 1", fq0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: done=%b one cycle after pulse, expected 0", done0);
        end
    endtask

    task automatic test_back_to_back();
        run_req0(1'b0, 1'b0, 1'b1, 1'b0, "b2b0");
        run_req0(1'b0, 1'b0, 1'b0, 1'b0, "b2b1");
        run_req0(1'b1, 1'b1, 1'b0, 1'b0, "b2b2");
        checks++;
        if (errc0 !== 8'd0 || fq0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: err_count=%0d q=%b, expected 0 1", errc0, fq0);
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            valid1  = 1'b1;
            target1 = (i == 0);
            @(posedge clk);
            @(negedge clk);
            valid1 = 1'b0;
            checks++;
            if (j1 !== 1'b1 || k1 !== 1'b1) begin
                errors++;
                $display("FAIL toggle%0d_drive: j=%b k=%b, expected 1 1", i, j1, k1);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (done1 !== 1'b1 || mis1 !== 1'b0 || fq1 !== (i == 0)) begin
                errors++;
                $display("FAIL toggle%0d_done: done=%b mis=%b q=%b, expected 1 0 %b",
                         i, done1, mis1, fq1, i == 0);
            end
        end
    endtask

    task automatic test_saturate();
        int exp_cnt;
        stuck = 1'b1;
        for (int i = 0; i < 300; i++) begin
            run_req0(1'b1, 1'b1, 1'b0, 1'b1, "stuck");
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            checks++;
            if (errc0 !== exp_cnt[7:0]) begin
                errors++;
                $display("FAIL stuck_count%0d: err_count=%0d, expected %0d", i, errc0, exp_cnt);
            end
        end
        checks++;
        if (rail0 !== 1'b1 || errc0 !== 8'd255) begin
            errors++;
            $display("FAIL stuck_end: rail_err=%b err_count=%0d, expected 1 255", rail0, errc0);
        end
    endtask

    task automatic test_reset_mid_drive();
        stuck   = 1'b0;
        valid0  = 1'b1;
        target0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        checks++;
        if (j0 !== 1'b0 || k0 !== 1'b1) begin
            errors++;
            $display("FAIL abort_drive: j=%b k=%b, expected 0 1", j0, k0);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (j0 !== 1'b0 || k0 !== 1'b0 || done0 !== 1'b0 || ffrn0 !== 1'b0 ||
            errc0 !== 8'd0 || rail0 !== 1'b0 || ready0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: j=%b k=%b done=%b ffrn=%b err=%0d rail=%b ready=%b, expected all 0",
                     j0, k0, done0, ffrn0, errc0, rail0, ready0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (done0 !== 1'b0 || ready0 !== (c >= 3) || ffrn0 !== (c >= 3)) begin
                errors++;
                $display("FAIL abort_reinit%0d: done=%b ready=%b ffrn=%b, expected 0 %b %b",
                         c, done0, ready0, ffrn0, c >= 3, c >= 3);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_toggle();
        test_saturate();
        @(negedge clk);
        test_reset_mid_drive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_excite_driver.md
# jk_excite_driver

Sequential driver for the lab's JK flip-flop interface: the initiating end that produces `j`, `k` and the flip-flop's active-low reset, and reads back `q`/`q_`. It accepts one target state per request over a valid/ready handshake and derives the excitation from the JK excitation table and the flip-flop's current `q`. It then drives `j`/`k`, returns them to hold (0/0), and checks that the flip-flop reached the target. It sits between a request source (test sequencer or counter logic) and one JK flip-flop instance, all on a single clock.

## Interface
- `RST_CYCLES`, default 2: cycles `ff_reset_n` is held low after reset release (≥1).
- `DRIVE_CYCLES`, default 1: cycles `j`/`k` carry the excitation (≥1).
- `SETTLE_CYCLES`, default 1: cycles of `j=k=0` before the check (≥1).
- `USE_TOGGLE`, default 0: 1 = state changes use `j=k=1`; 0 = set/reset encoding.
- `ERR_W`, default 8: width of `err_count`.

- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: driver can accept a request.
- `req_target` input 1: desired flip-flop state.
- `j`, `k` output 1 each: registered JK drive.
- `ff_reset_n` output 1: registered active-low reset to the flip-flop.
- `q`, `q_` input 1 each: flip-flop outputs, synchronous to `clk`.
- `done` output 1: one-cycle pulse, request finished.
- `mismatch` output 1: valid with `done`; 1 = `q` ≠ target.
- `rail_err` output 1: sticky; `q == q_` seen at a check.
- `err_count` output ERR_W: saturating count of mismatches.

## Operation
- States: INIT, IDLE, DRIVE, SETTLE, CHECK.
- Reset (sampled high at an edge) applies regardless of state.
  - Next state is INIT.
  - `ff_reset_n=0`, `j=k=0`, `req_ready=0`, `done=0`, `mismatch=0`, `rail_err=0`, `err_count=0`.
- INIT: `ff_reset_n=0` for RST_CYCLES cycles after reset deasserts, then IDLE with `ff_reset_n=1`.
- IDLE: `req_ready=1`.
  - A request is accepted on an edge where `req_valid & req_ready` holds.
  - That edge captures `req_target` and the current `q` (q0).
- Excitation with USE_TOGGLE=0:
  - 0→0: j=0, k=0.
  - 0→1: j=1, k=0.
  - 1→0: j=0, k=1.
  - 1→1: j=0, k=0.
- With USE_TOGGLE=1, 0→1 and 1→0 use j=1, k=1. Holds are unchanged.
- DRIVE: outputs the excitation for DRIVE_CYCLES cycles, then SETTLE.
- SETTLE: `j=k=0` for SETTLE_CYCLES cycles, then CHECK.
- CHECK: one cycle. At its closing edge:
  - `q` is compared with the captured target.
  - `q == q_` sets `rail_err`.
  - The next state is IDLE.
- Mismatch: `err_count` increments and saturates at 2^ERR_W−1, no wrap.
- `j`, `k` and `ff_reset_n` are glitch-free registered outputs. `j=k=0` in every state except DRIVE.
- `req_target` and `req_valid` are ignored outside IDLE.

## Timing
- Accept at edge N. DRIVE covers cycles N+1..N+D, SETTLE covers N+D+1..N+D+S, CHECK covers N+D+S+1 (D=DRIVE_CYCLES, S=SETTLE_CYCLES).
- `done` (and `mismatch`) are high only in cycle N+D+S+2, the first IDLE cycle.
- `req_ready` is also high in that cycle, so back-to-back requests are accepted with no bubble.
- With defaults, accept-to-`done` latency is 4 edges and throughput is one request per 4 cycles.
- After reset deasserts, `req_ready` first rises RST_CYCLES+1 cycles later.
- Reset mid-DRIVE/SETTLE/CHECK: the next edge drops `j`/`k` to 0, aborts the request with no `done`, and clears counters.
- `req_valid` high while `req_ready=0` is a legal stall. The request is held by the source and accepted on the next IDLE edge.

## Test plan
- Reset for 2 cycles, then release → `ff_reset_n=0` for exactly 2 cycles, `req_ready` rises in the 3rd cycle, all other outputs 0, FF `q=0`.
- From `q=0`, request target=1 (USE_TOGGLE=0) → one cycle of j=1/k=0, then j=k=0; `done=1`, `mismatch=0` 4 cycles after accept; `q=1`.
- From `q=1`, back-to-back targets 0, 0, 1 → j/k sequence 01, 00, 10; three `done` pulses 4 cycles apart; `err_count=0`.
- USE_TOGGLE=1, targets 1 then 0 → j=k=1 both times; `q` toggles 0→1→0; no mismatch.
- FF model stuck at `q=0`, `q_=0`, 300 requests of target=1 → `mismatch=1` each `done`, `err_count` saturates at 255, `rail_err=1`.
- Reset asserted in the DRIVE cycle of a request → `j=k=0` next edge, no `done`, re-enters INIT with `err_count=0`.
